// File: rtl/alu.sv
// Registered 16-function arithmetic/logic unit for the execute stage.
// Inputs are sampled every rising edge; result and flag hold until the next edge.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EQ   = 4'd15
  } alu_op_e;

  alu_op_e            op;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;

  logic [WIDTH-1:0]   alu_out_d, alu_out_q;
  logic               carry_d, carry_q;

  assign op   = alu_op_e'(alu_sel);
  assign sum  = {1'b0, a} + {1'b0, b};
  // The extra top bit of the widened difference is the borrow out.
  assign diff = {1'b0, a} - {1'b0, b};
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign quot = (b == '0) ? '1 : a / b;

  always_comb begin
    // NOTE: both outputs get a default before the case, so no code path can infer a latch.
    alu_out_d = '0;
    carry_d   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_out_d = sum[WIDTH-1:0];
        carry_d   = sum[WIDTH];
      end
      OP_SUB: begin
        alu_out_d = diff[WIDTH-1:0];
        carry_d   = diff[WIDTH];
      end
      OP_MUL: begin
        alu_out_d = prod[WIDTH-1:0];
        carry_d   = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        alu_out_d = quot;
        carry_d   = (b == '0);
      end
      OP_SHL: begin
        alu_out_d = {a[WIDTH-2:0], 1'b0};
        carry_d   = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_out_d = {1'b0, a[WIDTH-1:1]};
        carry_d   = a[0];
      end
      OP_ROL:  alu_out_d = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  alu_out_d = {a[0], a[WIDTH-1:1]};
      OP_AND:  alu_out_d = a & b;
      OP_OR:   alu_out_d = a | b;
      OP_XOR:  alu_out_d = a ^ b;
      OP_NOR:  alu_out_d = ~(a | b);
      OP_NAND: alu_out_d = ~(a & b);
      OP_XNOR: alu_out_d = ~(a ^ b);
      OP_GT:   alu_out_d = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_EQ:   alu_out_d = {{(WIDTH-1){1'b0}}, (a == b)};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers are written with <= so every flop samples pre-edge values.
    if (rst) begin
      alu_out_q <= '0;
      carry_q   <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      carry_q   <= carry_d;
    end
  end

  assign alu_out = alu_out_q;
  assign carry   = carry_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases with literal expectations, then
// random traffic compared against an integer-arithmetic reference model.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b, alu_out;
  logic [3:0] alu_sel;
  logic       carry;

  int n_asserts = 0;
  int n_fail    = 0;

  alu #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .alu_sel (alu_sel),
    .alu_out (alu_out),
    .carry   (carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input string tag, input logic [7:0] eo, input logic ec);
    check({tag, ".out"}, alu_out, eo);
    check({tag, ".carry"}, {7'b0, carry}, {7'b0, ec});
  endtask

  // Drive inputs, let one rising edge sample them, then settle past the edge.
  task automatic apply(input logic r, input logic [7:0] ai, input logic [7:0] bi,
                       input logic [3:0] s);
    rst = r; a = ai; b = bi; alu_sel = s;
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour in plain integer arithmetic, 8-bit unsigned operands.
  function automatic void model(input int sel, input int ai, input int bi,
                                output int r, output bit c);
    c = 1'b0;
    case (sel)
      0:  begin r = ai + bi; c = (r > 255); end
      1:  begin r = (ai - bi + 256) % 256; c = (ai < bi); end
      2:  begin r = ai * bi; c = (r > 255); end
      3:  if (bi == 0) begin r = 255; c = 1'b1; end else r = ai / bi;
      4:  begin r = ai * 2; c = (ai >= 128); end
      5:  begin r = ai / 2; c = (ai % 2 == 1); end
      6:  r = (ai * 2) % 256 + ai / 128;
      7:  r = ai / 2 + (ai % 2) * 128;
      8:  r = ai & bi;
      9:  r = ai | bi;
      10: r = ai ^ bi;
      11: r = 255 - (ai | bi);
      12: r = 255 - (ai & bi);
      13: r = 255 - (ai ^ bi);
      14: r = (ai > bi) ? 1 : 0;
      default: r = (ai == bi) ? 1 : 0;
    endcase
    r = r % 256;
  endfunction

  logic [7:0] sweep_exp [16] = '{8'd12, 8'd8, 8'd20, 8'd5, 8'd20, 8'd5, 8'd20, 8'd5,
                                 8'd2, 8'd10, 8'd8, 8'hF5, 8'hFD, 8'hF7, 8'd1, 8'd0};

  initial begin
    // Reset held for two edges, then the first real result.
    apply(1'b1, 8'h0A, 8'h02, 4'd0);
    expect_res("reset0", 8'h00, 1'b0);
    apply(1'b1, 8'h0A, 8'h02, 4'd0);
    expect_res("reset1", 8'h00, 1'b0);
    apply(1'b0, 8'h0A, 8'h02, 4'd0);
    expect_res("first_add", 8'd12, 1'b0);

    // Output must hold while inputs change between edges.
    a = 8'h00; b = 8'h00; alu_sel = 4'd8;
    #3;
    expect_res("hold", 8'd12, 1'b0);

    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 8'd10, 8'd2, 4'(i));
      expect_res($sformatf("sweep%0d", i), sweep_exp[i], 1'b0);
    end

    apply(1'b0, 8'hF6, 8'h0A, 4'd0);  expect_res("ovf_add", 8'h00, 1'b1);
    apply(1'b0, 8'hF6, 8'h0A, 4'd1);  expect_res("ovf_sub", 8'hEC, 1'b0);
    apply(1'b0, 8'hF6, 8'h0A, 4'd2);  expect_res("ovf_mul", 8'h9C, 1'b1);
    apply(1'b0, 8'hF6, 8'h0A, 4'd3);  expect_res("ovf_div", 8'd24, 1'b0);
    apply(1'b0, 8'hF6, 8'h0A, 4'd4);  expect_res("ovf_shl", 8'hEC, 1'b1);
    apply(1'b0, 8'hF6, 8'h0A, 4'd6);  expect_res("ovf_rol", 8'hED, 1'b0);
    apply(1'b0, 8'hF6, 8'h0A, 4'd14); expect_res("ovf_gt", 8'h01, 1'b0);
    apply(1'b0, 8'h81, 8'h00, 4'd5);  expect_res("shr_lsb", 8'h40, 1'b1);
    apply(1'b0, 8'h81, 8'h00, 4'd7);  expect_res("ror_lsb", 8'hC0, 1'b0);

    apply(1'b0, 8'd2, 8'd10, 4'd1);   expect_res("borrow", 8'hF8, 1'b1);
    apply(1'b0, 8'h5A, 8'h5A, 4'd15); expect_res("eq", 8'h01, 1'b0);

    apply(1'b0, 8'h33, 8'h00, 4'd3);  expect_res("div0", 8'hFF, 1'b1);
    apply(1'b0, 8'h33, 8'h00, 4'd0);  expect_res("after_div0", 8'h33, 1'b0);

    apply(1'b0, 8'hF6, 8'h0A, 4'd2);  expect_res("mid_pre", 8'h9C, 1'b1);
    apply(1'b1, 8'hF6, 8'h0A, 4'd2);  expect_res("mid_rst", 8'h00, 1'b0);
    apply(1'b0, 8'hF6, 8'h0A, 4'd2);  expect_res("mid_post", 8'h9C, 1'b1);

    // Random back-to-back traffic with occasional zero divisors, equal operands and resets.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra, rb;
      logic [3:0] rs;
      logic       rr;
      int         er;
      bit         ec;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 4'($urandom);
      rr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) rb = 8'h00;
      if ($urandom_range(0, 7) == 0) rb = ra;
      model(int'(rs), int'(ra), int'(rb), er, ec);
      if (rr) begin
        er = 0;
        ec = 1'b0;
      end
      apply(rr, ra, rb, rs);
      expect_res($sformatf("rand%0d_sel%0d_a%02h_b%02h", i, rs, ra, rb), 8'(er), ec);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
